// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage controller and alu_seq.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             S;
    logic             Z;
    logic             C;
    logic             V;
    logic             illegal;

    // Pipeline controller side: issues requests, consumes results.
    modport master (
        output in_valid, op, a, b, shamt, abort, out_ready,
        input  in_ready, out_valid, result, S, Z, C, V, illegal
    );

    // ALU side.
    modport slave (
        input  in_valid, op, a, b, shamt, abort, out_ready,
        output in_ready, out_valid, result, S, Z, C, V, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, iterative shifts and
// shift-add multiply, S/Z/C/V flag register, abort flush.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  io_alu
);
    // Counter must hold WIDTH for multiply, hence one bit above SHW.
    localparam int unsigned CW = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_NOP = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_finish;
    logic             w_iter;

    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic             r_shc;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_load;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_illegal;
    logic [WIDTH-1:0] r_result;
    logic             r_s;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    logic [WIDTH:0]   w_add_ext;
    logic [WIDTH:0]   w_sub_ext;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_s;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_ill;
    logic             w_std_flags;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort overrides accept, completion and out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!io_alu.abort && io_alu.in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (io_alu.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (io_alu.abort || io_alu.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Iteration count loaded at accept: shamt for shifts, WIDTH for multiply.
    always_comb begin
        w_cnt_load = '0;
        case (io_alu.op)
            OP_SLL, OP_ROL, OP_SRL, OP_SRA: w_cnt_load = CW'(io_alu.shamt);
            OP_MUL:                         w_cnt_load = CW'(WIDTH);
            default:                        w_cnt_load = '0;
        endcase
    end

    assign w_iter    = (r_state == ST_EXEC) && !io_alu.abort && (r_cnt != '0);
    assign w_mul_sum = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : '0);

    // Operand capture and one shift / multiply step per EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_shc <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op  <= io_alu.op;
            r_a   <= io_alu.a;
            r_b   <= io_alu.b;
            r_hi  <= '0;
            r_shc <= 1'b0;
            r_cnt <= w_cnt_load;
        end else if (w_iter) begin
            r_cnt <= r_cnt - CW'(1);
            case (r_op)
                OP_SLL: begin
                    r_shc <= r_b[WIDTH-1];
                    r_b   <= {r_b[WIDTH-2:0], 1'b0};
                end
                OP_ROL: begin
                    r_b   <= {r_b[WIDTH-2:0], r_b[WIDTH-1]};
                end
                OP_SRL: begin
                    r_shc <= r_b[0];
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                end
                OP_SRA: begin
                    r_shc <= r_b[0];
                    r_b   <= {r_b[WIDTH-1], r_b[WIDTH-1:1]};
                end
                OP_MUL: begin
                    // Product accumulates in {r_hi, r_b}; multiplier bits retire from r_b[0].
                    r_hi  <= w_mul_sum[WIDTH:1];
                    r_b   <= {w_mul_sum[0], r_b[WIDTH-1:1]};
                end
                default: begin
                    r_b   <= r_b;
                end
            endcase
        end
    end

    // Final result and flag values presented on the completing EXEC cycle.
    always_comb begin
        w_add_ext   = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
        w_sub_ext   = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
        w_res       = '0;
        w_s         = r_s;
        w_z         = r_z;
        w_c         = r_c;
        w_v         = r_v;
        w_ill       = 1'b0;
        w_std_flags = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_add_ext[WIDTH-1:0];
                w_s   = w_add_ext[WIDTH];
                w_z   = (w_add_ext[WIDTH-1:0] == '0);
                // Unsigned carry recovered from the sign-extended sum.
                w_c   = w_add_ext[WIDTH] ^ r_a[WIDTH-1] ^ r_b[WIDTH-1];
                w_v   = w_add_ext[WIDTH] ^ w_add_ext[WIDTH-1];
            end
            OP_SUB, OP_CMP: begin
                w_res = (r_op == OP_CMP) ? r_a : w_sub_ext[WIDTH-1:0];
                w_s   = w_sub_ext[WIDTH];
                w_z   = (w_sub_ext[WIDTH-1:0] == '0);
                w_c   = (r_a < r_b);
                w_v   = w_sub_ext[WIDTH] ^ w_sub_ext[WIDTH-1];
            end
            OP_AND: begin
                w_res = r_a & r_b;
                w_c   = 1'b0;
                w_std_flags = 1'b1;
            end
            OP_OR: begin
                w_res = r_a | r_b;
                w_c   = 1'b0;
                w_std_flags = 1'b1;
            end
            OP_XOR: begin
                w_res = r_a ^ r_b;
                w_c   = 1'b0;
                w_std_flags = 1'b1;
            end
            OP_MOV: begin
                w_res = r_b;
                w_c   = 1'b0;
                w_std_flags = 1'b1;
            end
            OP_NOP: begin
                w_res = r_a;
            end
            OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
                w_res = r_b;
                w_c   = r_shc;
                w_std_flags = 1'b1;
            end
            OP_MUL: begin
                w_res = r_b;
                w_c   = |r_hi;
                w_std_flags = 1'b1;
            end
            default: begin
                w_res = '0;
                w_ill = 1'b1;
            end
        endcase
        if (w_std_flags) begin
            w_s = w_res[WIDTH-1];
            w_z = (w_res == '0);
            w_v = 1'b0;
        end
    end

    // Result, flags and handshake outputs; flags only move on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_s         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            if (w_finish) begin
                r_result  <= w_res;
                r_s       <= w_s;
                r_z       <= w_z;
                r_c       <= w_c;
                r_v       <= w_v;
                r_illegal <= w_ill;
            end else if (w_state_nxt != ST_DONE) begin
                r_illegal <= 1'b0;
            end
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_in_ready  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign io_alu.in_ready  = r_in_ready;
    assign io_alu.out_valid = r_out_valid;
    assign io_alu.result    = r_result;
    assign io_alu.S         = r_s;
    assign io_alu.Z         = r_z;
    assign io_alu.C         = r_c;
    assign io_alu.V         = r_v;
    assign io_alu.illegal   = r_illegal;

endmodule
